// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle core sequencing FETCH/EXEC/MEM with wait-state memory handshakes
// and a bounded hardware return stack. Define CPU_MUL_EN to add the MUL opcode (13).
module cpu_multicycle #(
    parameter int XLEN        = 19,
    parameter int REG_AW      = 4,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halted,
    output logic            fault
);
    localparam int IMM_W = XLEN - 5 - 2 * REG_AW;
    localparam int TGT_W = XLEN - 5;
    localparam int SA_W  = $clog2(STACK_DEPTH);
    localparam int SP_W  = SA_W + 1;
    localparam int NREG  = 2 ** REG_AW;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_ADDI = 5'd6;
    localparam logic [4:0] OP_LD   = 5'd7;
    localparam logic [4:0] OP_ST   = 5'd8;
    localparam logic [4:0] OP_BEQ  = 5'd9;
    localparam logic [4:0] OP_JMP  = 5'd10;
    localparam logic [4:0] OP_CALL = 5'd11;
    localparam logic [4:0] OP_RET  = 5'd12;
`ifdef CPU_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'd13;
`endif
    localparam logic [4:0] OP_HALT = 5'd31;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   ir;
    logic [XLEN-1:0]   regs  [NREG];
    logic [XLEN-1:0]   stack [STACK_DEPTH];
    logic [SP_W-1:0]   sp;

    logic [4:0]        op;
    logic [REG_AW-1:0] rd_a;
    logic [REG_AW-1:0] rs1_a;
    logic [XLEN-1:0]   rd_v;
    logic [XLEN-1:0]   rs1_v;
    logic [XLEN-1:0]   imm_z;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   tgt_z;
    logic [XLEN-1:0]   pc_inc;
    logic [SA_W-1:0]   top;

    assign op     = ir[XLEN-1 -: 5];
    assign rd_a   = ir[XLEN-6 -: REG_AW];
    assign rs1_a  = ir[XLEN-6-REG_AW -: REG_AW];
    assign rd_v   = regs[rd_a];
    assign rs1_v  = regs[rs1_a];
    assign imm_z  = {{(XLEN-IMM_W){1'b0}}, ir[IMM_W-1:0]};
    assign imm_s  = {{(XLEN-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign tgt_z  = {{(XLEN-TGT_W){1'b0}}, ir[TGT_W-1:0]};
    assign pc_inc = pc + XLEN'(1);
    assign top    = SA_W'(sp - SP_W'(1));

    logic            exc;
    logic            is_mem;
    logic            is_halt;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic [XLEN-1:0] wr_val;
    logic [XLEN-1:0] next_pc;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        exc     = 1'b0;
        is_mem  = 1'b0;
        is_halt = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        wr_en   = 1'b0;
        wr_val  = rd_v;
        next_pc = pc_inc;
        case (op)
            OP_NOP:  ;
            OP_ADD:  begin wr_en = 1'b1; wr_val = rd_v + rs1_v; end
            OP_SUB:  begin wr_en = 1'b1; wr_val = rd_v - rs1_v; end
            OP_AND:  begin wr_en = 1'b1; wr_val = rd_v & rs1_v; end
            OP_OR:   begin wr_en = 1'b1; wr_val = rd_v | rs1_v; end
            OP_XOR:  begin wr_en = 1'b1; wr_val = rd_v ^ rs1_v; end
            OP_ADDI: begin wr_en = 1'b1; wr_val = rs1_v + imm_z; end
            OP_LD, OP_ST: is_mem = 1'b1;
            OP_BEQ:  if (rd_v == rs1_v) next_pc = pc_inc + imm_s;
            OP_JMP:  next_pc = tgt_z;
            OP_CALL: begin
                if (sp == SP_W'(STACK_DEPTH)) begin
                    exc = 1'b1;
                end else begin
                    push    = 1'b1;
                    next_pc = tgt_z;
                end
            end
            OP_RET: begin
                if (sp == '0) begin
                    exc = 1'b1;
                end else begin
                    pop     = 1'b1;
                    next_pc = stack[top];
                end
            end
`ifdef CPU_MUL_EN
            OP_MUL:  begin wr_en = 1'b1; wr_val = rd_v * rs1_v; end
`endif
            OP_HALT: begin is_halt = 1'b1; next_pc = pc; end
            default: exc = 1'b1;
        endcase
    end

    // Register file write port is shared by EXEC results and load data returning in MEM.
    logic            rf_we;
    logic [XLEN-1:0] rf_wd;

    always_comb begin
        rf_we = 1'b0;
        rf_wd = wr_val;
        if (state == S_EXEC && wr_en) begin
            rf_we = 1'b1;
        end else if (state == S_MEM && dmem_ready && !dmem_we) begin
            rf_we = 1'b1;
            rf_wd = dmem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (rf_we && rd_a != '0) begin
            regs[rd_a] <= rf_wd;
        end
    end

    // NOTE: stack entries are only read below the stack pointer, so they need no reset.
    always_ff @(posedge clk) begin
        if (!reset && state == S_EXEC && push) stack[sp[SA_W-1:0]] <= pc_inc;
    end

    // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            sp         <= '0;
            fault      <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir    <= imem_rdata;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exc) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        pc <= next_pc;
                        if (push) sp <= sp + SP_W'(1);
                        if (pop)  sp <= sp - SP_W'(1);
                        if (is_mem) begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_ST);
                            dmem_addr  <= rs1_v + imm_z;
                            dmem_wdata <= rd_v;
                            state      <= S_MEM;
                        end else if (is_halt) begin
                            state <= S_HALT;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: state <= S_HALT;
            endcase
        end
    end

    assign imem_req  = (state == S_FETCH) && !reset;
    assign imem_addr = pc;
    assign halted    = (state == S_HALT);
    assign retire    = !reset &&
                       ((state == S_EXEC && !exc && !is_mem) || (state == S_MEM && dmem_ready));

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed self-checking bench for cpu_multicycle: ALU, load/store wait states, branches,
// call/return stack limits, illegal opcodes, MUL option and reset during a data wait.
module tb_cpu_multicycle;
    localparam int XLEN = 19;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready = 1'b0;
    logic [XLEN-1:0] dmem_rdata = '0;
    logic            retire;
    logic            halted;
    logic            fault;

    cpu_multicycle #(.XLEN(XLEN), .REG_AW(4), .STACK_DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .retire     (retire),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0] prog [256];
    logic [XLEN-1:0] dmem [256];
    int dmem_delay = 0;
    int dmem_cnt   = 0;
    int checks     = 0;
    int errors     = 0;

    // Zero-wait instruction memory.
    assign imem_ready = imem_req;
    assign imem_rdata = prog[imem_addr[7:0]];

    // Data memory: ready after dmem_delay wait cycles; stores commit on the ready edge.
    always @(posedge clk) begin
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
        #2;
        if (dmem_req) begin
            dmem_ready = (dmem_cnt >= dmem_delay);
            dmem_rdata = dmem[dmem_addr[7:0]];
            dmem_cnt++;
        end else begin
            dmem_ready = 1'b0;
            dmem_cnt   = 0;
        end
    end

    logic            rt  [32];
    logic            dq  [32];
    logic            dw  [32];
    logic [XLEN-1:0] da  [32];
    logic [XLEN-1:0] dd  [32];
    logic            hl  [32];
    logic            ft  [32];
    logic            irq [32];
    logic [XLEN-1:0] ia  [32];
    int              fq  [$];
    int              rc;
    int              exp_c [8]  = '{0, 1, 2, 10, 9, 10, 11, 64};
    int              exp_d [17] = '{0, 16, 32, 48, 64, 80, 96, 112, 128, 113, 97, 81, 65, 49, 33, 17, 1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] enc(input int op, input int rd, input int rs1, input int imm);
        return {op[4:0], rd[3:0], rs1[3:0], imm[5:0]};
    endfunction

    function automatic logic [XLEN-1:0] encj(input int op, input int tgt);
        return {op[4:0], tgt[13:0]};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            prog[i] = '0;
            dmem[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #2;
    endtask

    task automatic run_fetch_trace(input int ncyc);
        fq.delete();
        rc = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) next_cycle();
            if (imem_req) fq.push_back(int'(imem_addr));
            rc += int'(retire);
        end
    endtask

    initial begin
        // Phase A: ALU sequence, store/load with two wait cycles, HALT.
        clear_mem();
        prog[0] = enc(6, 1, 0, 5);
        prog[1] = enc(6, 2, 0, 7);
        prog[2] = enc(1, 1, 2, 0);
        prog[3] = enc(8, 1, 0, 3);
        prog[4] = enc(7, 3, 0, 3);
        prog[5] = enc(8, 3, 0, 4);
        prog[6] = encj(31, 0);
        dmem_delay = 2;
        do_reset();
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_dmem", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 64'd0);
        check("rst_status", {retire, halted, fault}, 64'd0);
        release_reset();
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) next_cycle();
            rt[c] = retire;     dq[c] = dmem_req;  dw[c] = dmem_we;
            da[c] = dmem_addr;  dd[c] = dmem_wdata;
            hl[c] = halted;     ft[c] = fault;
            irq[c] = imem_req;  ia[c] = imem_addr;
        end
        check("c1_fetch", {irq[1], ia[1]}, {1'b1, 19'd0});
        check("retire_c1_7", {rt[7], rt[6], rt[5], rt[4], rt[3], rt[2], rt[1]}, 64'b0101010);
        check("fault_c7", 64'(ft[7]), 64'd0);
        for (int c = 9; c <= 11; c++)
            check($sformatf("st_hold_c%0d", c), {dq[c], dw[c], da[c], dd[c]},
                  {1'b1, 1'b1, 19'd3, 19'd12});
        check("st_release", 64'(dq[12]), 64'd0);
        check("st_retire", {rt[10], rt[11]}, 64'b01);
        check("ld_req", {dq[14], dw[14], da[14]}, {1'b1, 1'b0, 19'd3});
        check("ld_retire_5th", {rt[15], rt[16]}, 64'b01);
        check("r3_store", {dq[19], dw[19], da[19], dd[19]}, {1'b1, 1'b1, 19'd4, 19'd12});
        check("dmem3", 64'(dmem[3]), 64'd12);
        check("dmem4", 64'(dmem[4]), 64'd12);
        check("halt_entry", {hl[23], hl[24], ft[24], irq[24]}, 64'b0100);

        // Phase B: reset while a load waits for dmem_ready.
        clear_mem();
        prog[0] = enc(6, 1, 0, 5);
        prog[1] = enc(7, 2, 1, 0);
        dmem_delay = 1000;
        do_reset();
        release_reset();
        repeat (4) next_cycle();
        check("wait_dmem", {dmem_req, dmem_addr, imem_addr}, {1'b1, 19'd5, 19'd2});
        reset = 1'b1;
        next_cycle();
        check("abort_dmem_req", 64'(dmem_req), 64'd0);
        check("abort_pc", {imem_req, imem_addr}, {1'b0, 19'd0});
        release_reset();
        check("refetch_0", {imem_req, imem_addr}, {1'b1, 19'd0});
        next_cycle();
        check("refetch_retire", 64'(retire), 64'd1);

        // Phase C: BEQ taken/not taken and JMP.
        clear_mem();
        prog[0]  = enc(6, 1, 0, 1);
        prog[1]  = enc(6, 2, 0, 1);
        prog[2]  = encj(10, 10);
        prog[9]  = enc(6, 2, 0, 2);
        prog[10] = enc(9, 1, 2, 62);
        prog[11] = encj(10, 64);
        prog[64] = encj(31, 0);
        dmem_delay = 0;
        do_reset();
        release_reset();
        run_fetch_trace(20);
        check("br_fetch_count", 64'(fq.size()), 64'd8);
        for (int i = 0; i < 8 && i < fq.size(); i++)
            check($sformatf("br_fetch%0d", i), 64'(fq[i]), 64'(exp_c[i]));
        check("br_status", {halted, fault}, 64'b10);

        // Phase D1: eight nested CALLs, eight RETs, then RET on an empty stack.
        clear_mem();
        for (int k = 0; k < 8; k++) begin
            prog[16*k]     = encj(11, 16*(k+1));
            prog[16*k + 1] = encj(12, 0);
        end
        prog[128] = encj(12, 0);
        do_reset();
        release_reset();
        run_fetch_trace(40);
        check("ret_fetch_count", 64'(fq.size()), 64'd17);
        for (int i = 0; i < 17 && i < fq.size(); i++)
            check($sformatf("ret_fetch%0d", i), 64'(fq[i]), 64'(exp_d[i]));
        check("ret_empty_fault", {fault, halted}, 64'b11);
        check("ret_retire_count", 64'(rc), 64'd16);

        // Phase D2: ninth CALL overflows the stack.
        prog[128] = encj(11, 200);
        do_reset();
        release_reset();
        run_fetch_trace(24);
        check("ovf_status", {fault, halted, imem_req}, 64'b110);
        check("ovf_pc", 64'(imem_addr), 64'd128);
        check("ovf_retire_count", 64'(rc), 64'd8);

        // Phase E: opcode 13.
        clear_mem();
        prog[0] = enc(6, 1, 0, 6);
        prog[1] = enc(6, 2, 0, 7);
        prog[2] = enc(13, 1, 2, 0);
        prog[3] = enc(8, 1, 0, 0);
        prog[4] = encj(31, 0);
        dmem[0] = 19'h1234;
        do_reset();
        release_reset();
        repeat (14) next_cycle();
`ifdef CPU_MUL_EN
        check("mul_result", 64'(dmem[0]), 64'd42);
        check("mul_status", {fault, halted}, 64'b01);
`else
        check("mul_untouched", 64'(dmem[0]), 64'h1234);
        check("mul_illegal", {fault, halted}, 64'b11);
`endif

        // Phase F: opcode 20 is illegal in every build.
        clear_mem();
        prog[0] = encj(20, 0);
        do_reset();
        release_reset();
        run_fetch_trace(4);
        check("op20_status", {fault, halted, imem_req}, 64'b110);
        check("op20_retire", 64'(rc), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle successor to the single-cycle 19-bit core: one instruction at a time through a FETCH/EXEC/MEM state machine, with ready/valid-style wait-state handshakes to external instruction and data memories and a bounded hardware return stack for CALL/RET. It is the core instantiated at SoC top level. Memories and peripherals sit outside the block.

## Interface
- `XLEN`, 19: datapath, instruction and address width.
- `REG_AW`, 4: register address width; `2**REG_AW` registers.
- `STACK_DEPTH`, 8: return-stack entries (power of two, ≥2).

Ports:
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `imem_req`  out  1: fetch request, held until `imem_ready`.
- `imem_addr`  out  XLEN: fetch address (= PC).
- `imem_ready`  in  1: fetch complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  XLEN: instruction word.
- `dmem_req`  out  1: data request, held until `dmem_ready`.
- `dmem_we`  out  1: 1 = store, 0 = load.
- `dmem_addr`  out  XLEN: data address.
- `dmem_wdata`  out  XLEN: store data.
- `dmem_ready`  in  1: access complete; `dmem_rdata` valid for loads.
- `dmem_rdata`  in  XLEN: load data.
- `retire`  out  1: one-cycle pulse per completed instruction.
- `halted`  out  1: core in HALT state.
- `fault`  out  1: sticky; illegal opcode or stack over/underflow.

## Operation
- Format: opcode = `[XLEN-1:XLEN-5]`, rd next REG_AW bits, rs1 next REG_AW bits, imm = low `XLEN-5-2*REG_AW` bits; jump target = low `XLEN-5` bits, zero-extended.
- r0 reads 0; writes to r0 discarded. All registers clear on reset.
- Opcodes: 0 NOP; 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (rd ← rd op rs1); 6 ADDI (rd ← rs1 + zext imm); 7 LD (rd ← mem[rs1+zext imm]); 8 ST (mem[rs1+zext imm] ← rd); 9 BEQ (if rd==rs1, PC ← PC+1+sext imm); 10 JMP; 11 CALL (push PC+1, jump); 12 RET (pop to PC); 13 MUL (see Configuration); 31 HALT; others illegal.
- Arithmetic modulo 2^XLEN; no flags.
- States: FETCH → EXEC; EXEC → MEM (LD/ST), HALT (HALT or fault), else FETCH; MEM → FETCH on `dmem_ready`; HALT absorbing until reset.
- Fault: illegal opcode, CALL with stack full, RET with stack empty. Sets `fault`, no architectural update, enters HALT, no `retire`.
- PC wraps modulo 2^XLEN.

## Timing
- Reset values: PC=0, state FETCH, `imem_req`=0 in the reset cycle, all other outputs 0, stack pointer 0.
- FETCH: `imem_req`=1 and `imem_addr`=PC from the first cycle after reset deassert. The instruction latches on the cycle with `imem_ready`=1. Zero-wait fetch takes 1 cycle.
- EXEC: 1 cycle. Register write, PC update and push/pop occur at the end of EXEC. `retire` pulses in EXEC for non-memory instructions.
- MEM: `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` are stable from MEM entry until `dmem_ready`. The LD write and `retire` happen on the `dmem_ready` cycle.
- Minimum CPI: ALU/branch 2, LD/ST 3; each wait cycle adds 1.
- `*_ready` is ignored outside the matching request.
- Reset mid-transaction aborts immediately; the outstanding request drops next cycle.
- HALT: all requests 0, `halted`=1.

## Configuration
- `CPU_MUL_EN` defined: opcode 13 MUL, rd ← low XLEN bits of rd×rs1, single-cycle EXEC.
- `CPU_MUL_EN` undefined: opcode 13 is illegal and faults; no multiplier synthesised.

## Test plan
- Reset then ADDI r1,r0,5; ADDI r2,r0,7; ADD r1,r2 with zero-wait imem: r1=12, `retire` at cycles 2,4,6, `fault`=0.
- ST r1→[r0+3], then LD r3←[r0+3], `dmem_ready` delayed 2 cycles: `dmem_we`=1, addr 3, wdata 12 held 3 cycles; r3=12; LD retires in its 5th cycle.
- BEQ taken (r1==r1, imm=-2) at PC 10 → next fetch 9. BEQ not taken → next fetch 11. JMP 0x0040 → fetch 0x40.
- CALL nested 8 deep then RET ×8: returns to each pushed PC+1. A 9th CALL → `fault`=1, `halted`=1, PC unchanged. RET on an empty stack → fault.
- Opcode 13 → r = 6×7 = 42 with `CPU_MUL_EN`; `fault`=1 without it. Opcode 20 → `fault`=1 in both.
- `reset` asserted while `dmem_req` is waiting → next cycle `dmem_req`=0, PC=0. After deassert, a fetch from address 0 follows.
